// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_pkg
// Shared definitions for the common data bus (CDB) arbiter and the functional
// units that drive it: default widths, the "no tag" encoding and the message
// record that travels on the bus.
// -----------------------------------------------------------------------------
package cdb_pkg;

    localparam int N_REQ  = 4;   // default number of requesting units
    localparam int IDX_W  = 8;   // tag width
    localparam int DATA_W = 32;  // result / address width

    // Tag value reserved to mean "no producer"; never broadcast.
    localparam logic [IDX_W-1:0] TAG_NONE = '0;

    // One CDB message as produced by a functional unit.
    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] addr;
    } cdb_msg_t;

    // Width of a binary pointer over n units (at least one bit).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Request/grant handshake between the functional units and the arbiter, plus
// the registered CDB broadcast snooped by reservation stations and the ROB.
//   req        : per-unit level request
//   req_index  : per-unit tag,    unit k at [k*IDX_W  +: IDX_W]
//   req_result : per-unit result, unit k at [k*DATA_W +: DATA_W]
//   req_addr   : per-unit target, unit k at [k*DATA_W +: DATA_W]
//   grnt       : one-hot or zero grant, same cycle as the request
//   cdb_out_*  : broadcast valid / tag / result / address
// modport master : functional-unit side, slave : arbiter side.
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
    parameter int N_REQ  = cdb_pkg::N_REQ,
    parameter int IDX_W  = cdb_pkg::IDX_W,
    parameter int DATA_W = cdb_pkg::DATA_W
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*IDX_W-1:0]  req_index;
    logic [N_REQ*DATA_W-1:0] req_result;
    logic [N_REQ*DATA_W-1:0] req_addr;
    logic [N_REQ-1:0]        grnt;
    logic                    cdb_out_valid;
    logic [IDX_W-1:0]        cdb_out_index;
    logic [DATA_W-1:0]       cdb_out_result;
    logic [DATA_W-1:0]       cdb_out_addr;

    modport master (
        output req, req_index, req_result, req_addr,
        input  grnt, cdb_out_valid, cdb_out_index, cdb_out_result, cdb_out_addr
    );

    modport slave (
        input  req, req_index, req_result, req_addr,
        output grnt, cdb_out_valid, cdb_out_index, cdb_out_result, cdb_out_addr
    );
endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: picks the first set bit of req at or
// after ptr, wrapping from N_REQ-1 back to 0.
//   req : eligible requests
//   ptr : highest-priority position this cycle
//   gnt : one-hot winner (zero when req is zero)
//   win : binary index of the winner (0 when req is zero)
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] win
);

    logic             found;
    logic [PTR_W-1:0] k;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = PTR_W'((int'(ptr) + i) % N_REQ);
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                win    = k;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Round-robin arbiter and registered output stage for the common data bus.
// One requester is granted per cycle; its message appears on the CDB one cycle
// later. A branch flush (br) cancels the current arbitration, masks the
// broadcast already on the bus and clears the output stage.
//   clk          : clock, all state on posedge
//   rst          : synchronous active-high reset (wins over br)
//   br           : flush
//   bus          : request/grant and CDB broadcast (slave side)
//   conflict_cnt : saturating count of cycles with >= 2 eligible requests
//   err_zero_tag : sticky, set when a request carrying tag 0 is granted
// -----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_REQ  = cdb_pkg::N_REQ,
    parameter int IDX_W  = cdb_pkg::IDX_W,
    parameter int DATA_W = cdb_pkg::DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           br,
    cdb_arbiter_if.slave   bus,
    output logic [15:0]    conflict_cnt,
    output logic           err_zero_tag
);

    localparam int PTR_W = ptr_width(N_REQ);

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  win;
    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  gnt;
    logic              any_gnt;
    logic              multi_req;

    // Per-unit views of the flat payload buses.
    logic [IDX_W-1:0]  idx_a [N_REQ];
    logic [DATA_W-1:0] res_a [N_REQ];
    logic [DATA_W-1:0] adr_a [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign idx_a[g] = bus.req_index[g*IDX_W +: IDX_W];
        assign res_a[g] = bus.req_result[g*DATA_W +: DATA_W];
        assign adr_a[g] = bus.req_addr[g*DATA_W +: DATA_W];
    end

    // Output stage registers.
    logic              v_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] res_q;
    logic [DATA_W-1:0] adr_q;

    // A flush suppresses every request in the same cycle.
    assign eligible  = br ? '0 : bus.req;
    assign multi_req = ($countones(eligible) >= 2);
    assign any_gnt   = |gnt;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req (eligible),
        .ptr (ptr),
        .gnt (gnt),
        .win (win)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            ptr          <= '0;
            v_q          <= 1'b0;
            idx_q        <= '0;
            res_q        <= '0;
            adr_q        <= '0;
            conflict_cnt <= '0;
            err_zero_tag <= 1'b0;
        end else if (br) begin
            // Counter and error flag deliberately hold across a flush.
            ptr   <= '0;
            v_q   <= 1'b0;
            idx_q <= '0;
            res_q <= '0;
            adr_q <= '0;
        end else begin
            if (multi_req && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;

            if (any_gnt) begin
                ptr   <= (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
                idx_q <= idx_a[win];
                res_q <= res_a[win];
                adr_q <= adr_a[win];
                // A tag-0 request is still granted so the unit drains, but
                // nothing is broadcast for it.
                v_q   <= (idx_a[win] != TAG_NONE[IDX_W-1:0]);
                if (idx_a[win] == TAG_NONE[IDX_W-1:0])
                    err_zero_tag <= 1'b1;
            end else begin
                v_q <= 1'b0;
            end
        end
    end

    assign bus.grnt           = gnt;
    // The broadcast already on the bus is masked during a flush cycle.
    assign bus.cdb_out_valid  = v_q & ~br;
    assign bus.cdb_out_index  = idx_q;
    assign bus.cdb_out_result = res_q;
    assign bus.cdb_out_addr   = adr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter: directed sequences, a vector table,
// randomized traffic against a priority-queue reference model, and counter
// saturation. Inputs change on negedge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        br;
    logic [15:0] conflict_cnt;
    logic        err_zero_tag;

    int n_total  = 0;
    int n_passed = 0;

    cdb_arbiter_if #(.N_REQ(N), .IDX_W(IDX_W), .DATA_W(DATA_W)) bus ();

    cdb_arbiter #(.N_REQ(N), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .br           (br),
        .bus          (bus),
        .conflict_cnt (conflict_cnt),
        .err_zero_tag (err_zero_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            n_passed++;
    endtask

    task automatic set_msg(input int k, input cdb_msg_t m);
        bus.req_index[k*IDX_W +: IDX_W]    = m.index;
        bus.req_result[k*DATA_W +: DATA_W] = m.result;
        bus.req_addr[k*DATA_W +: DATA_W]   = m.addr;
    endtask

    task automatic apply(input logic [N-1:0] r, input logic b);
        @(negedge clk);
        bus.req = r;
        br      = b;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        br      = 1'b0;
        bus.req = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // ---------------- reference model ----------------
    // Priority order kept as a queue of unit ids: the head has top priority,
    // and after a grant the winner moves to the tail.
    int       m_order[$];
    logic     m_v;
    cdb_msg_t m_msg;
    int       m_cnt;
    logic     m_err;

    function automatic void model_reset_order();
        m_order.delete();
        for (int i = 0; i < N; i++) m_order.push_back(i);
    endfunction

    function automatic void model_reset();
        model_reset_order();
        m_v = 1'b0; m_msg = '0; m_cnt = 0; m_err = 1'b0;
    endfunction

    function automatic int model_pick(input logic [N-1:0] r);
        foreach (m_order[i]) if (r[m_order[i]]) return m_order[i];
        return -1;
    endfunction

    function automatic void model_step(input logic [N-1:0] r, input logic b,
                                       input logic rs, input cdb_msg_t msgs [N]);
        int w;
        if (rs) begin
            model_reset();
        end else if (b) begin
            m_v = 1'b0; m_msg = '0;
            model_reset_order();
        end else begin
            w = model_pick(r);
            if ($countones(r) >= 2 && m_cnt < 65535) m_cnt++;
            if (w >= 0) begin
                m_msg = msgs[w];
                m_v   = (msgs[w].index != 0);
                if (msgs[w].index == 0) m_err = 1'b1;
                while (m_order[$] != w) m_order.push_back(m_order.pop_front());
            end else begin
                m_v = 1'b0;
            end
        end
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] req;
        logic         br;
        logic [N-1:0] grnt;
        logic         valid;
        logic [7:0]   index;
        logic [15:0]  cnt;
    } vec_t;

    vec_t     vecs [17];
    cdb_msg_t fixed [N];
    cdb_msg_t rmsg  [N];
    logic [N-1:0] exp_g;
    int       w;

    initial begin
        // Starts from ptr=2, data 05 on the output regs, valid 0, cnt 0.
        vecs[0]  = '{4'b0101, 1'b1, 4'b0000, 1'b0, 8'h05, 16'd0};
        vecs[1]  = '{4'b0101, 1'b1, 4'b0000, 1'b0, 8'h00, 16'd0};
        vecs[2]  = '{4'b0100, 1'b0, 4'b0100, 1'b0, 8'h00, 16'd0};
        vecs[3]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h33, 16'd0};
        vecs[4]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h33, 16'd0};
        vecs[5]  = '{4'b1111, 1'b0, 4'b0001, 1'b0, 8'h00, 16'd0};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 8'h11, 16'd1};
        vecs[7]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 8'h05, 16'd2};
        vecs[8]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 8'h33, 16'd3};
        vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h44, 16'd4};
        vecs[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h44, 16'd4};
        vecs[11] = '{4'b0001, 1'b0, 4'b0001, 1'b0, 8'h44, 16'd4};
        vecs[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 16'd4};
        vecs[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 16'd4};
        vecs[14] = '{4'b1010, 1'b0, 4'b0010, 1'b0, 8'h00, 16'd4};
        vecs[15] = '{4'b1010, 1'b0, 4'b1000, 1'b1, 8'h05, 16'd5};
        vecs[16] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 8'h44, 16'd6};

        fixed[0] = '{8'h11, 32'h0000_00A0, 32'h0000_0100};
        fixed[1] = '{8'h05, 32'h0000_1234, 32'h0000_0080};
        fixed[2] = '{8'h33, 32'h0000_3333, 32'h0000_0300};
        fixed[3] = '{8'h44, 32'h0000_4444, 32'h0000_0400};

        rst = 1'b1; br = 1'b0;
        bus.req = '0; bus.req_index = '0; bus.req_result = '0; bus.req_addr = '0;
        for (int k = 0; k < N; k++) set_msg(k, fixed[k]);

        // ---- reset state ----
        do_reset();
        check("reset_grnt",   bus.grnt, 0);
        check("reset_valid",  bus.cdb_out_valid, 0);
        check("reset_index",  bus.cdb_out_index, 0);
        check("reset_result", bus.cdb_out_result, 0);
        check("reset_addr",   bus.cdb_out_addr, 0);
        check("reset_cnt",    conflict_cnt, 0);
        check("reset_err",    err_zero_tag, 0);

        // ---- single request ----
        apply(4'b0010, 1'b0);
        check("single_grnt", bus.grnt, 4'b0010);
        check("single_valid_t", bus.cdb_out_valid, 0);
        apply(4'b0000, 1'b0);
        check("single_valid_t1", bus.cdb_out_valid, 1);
        check("single_index",  bus.cdb_out_index, 8'h05);
        check("single_result", bus.cdb_out_result, 32'h1234);
        check("single_addr",   bus.cdb_out_addr, 32'h80);
        apply(4'b0000, 1'b0);
        check("single_valid_t2", bus.cdb_out_valid, 0);

        // ---- table: flush, round-robin, flush after grant, wrap ----
        for (int i = 0; i < 17; i++) begin
            apply(vecs[i].req, vecs[i].br);
            check($sformatf("vec%0d_grnt", i),  bus.grnt, vecs[i].grnt);
            check($sformatf("vec%0d_valid", i), bus.cdb_out_valid, vecs[i].valid);
            check($sformatf("vec%0d_index", i), bus.cdb_out_index, vecs[i].index);
            check($sformatf("vec%0d_cnt", i),   conflict_cnt, vecs[i].cnt);
            check($sformatf("vec%0d_err", i),   err_zero_tag, 0);
        end

        // ---- zero tag (ptr is 0 here) ----
        set_msg(0, '{8'h00, 32'hDEAD, 32'hBEEF});
        apply(4'b0001, 1'b0);
        check("zero_grnt", bus.grnt, 4'b0001);
        apply(4'b0000, 1'b0);
        check("zero_valid",  bus.cdb_out_valid, 0);
        check("zero_result", bus.cdb_out_result, 32'hDEAD);
        check("zero_err",    err_zero_tag, 1);
        apply(4'b0000, 1'b1);
        apply(4'b0000, 1'b0);
        check("zero_err_after_flush", err_zero_tag, 1);
        do_reset();
        check("zero_err_cleared", err_zero_tag, 0);
        set_msg(0, fixed[0]);

        // ---- randomized traffic vs. model ----
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            rst     = (c == 0) || ($urandom_range(0, 199) == 0);
            br      = ($urandom_range(0, 19) == 0);
            bus.req = N'($urandom);
            for (int k = 0; k < N; k++) begin
                rmsg[k].index  = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
                rmsg[k].result = $urandom;
                rmsg[k].addr   = $urandom;
                set_msg(k, rmsg[k]);
            end
            #1;
            exp_g = '0;
            w = model_pick(bus.req);
            if (!br && w >= 0) exp_g[w] = 1'b1;
            if (!rst) check("rand_grnt", bus.grnt, exp_g);
            check("rand_valid",  bus.cdb_out_valid, m_v & ~br);
            check("rand_index",  bus.cdb_out_index, m_msg.index);
            check("rand_result", bus.cdb_out_result, m_msg.result);
            check("rand_addr",   bus.cdb_out_addr, m_msg.addr);
            check("rand_cnt",    conflict_cnt, m_cnt);
            check("rand_err",    err_zero_tag, m_err);
            model_step(bus.req, br, rst, rmsg);
        end

        // ---- counter saturation ----
        do_reset();
        bus.req = 4'b1111;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_fffe", conflict_cnt, 16'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        check("sat_ffff", conflict_cnt, 16'hFFFF);
        @(negedge clk);
        rst = 1'b1;
        bus.req = '0;
        @(posedge clk);
        #1;
        check("sat_rst_clear", conflict_cnt, 0);
        check("sat_rst_valid", bus.cdb_out_valid, 0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
